// File: rtl/mc14500_fetch.sv
// mc14500_fetch: PC owner, four-phase RAM fetch and valid/ready hand-off to the MC14500B ICU.
// Optional FETCH_ACK_SYNC_EN adds a 2-flop synchronizer on mem_ack.
module mc14500_fetch #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [ADDR_WIDTH-1:0] read_address,
    output logic                  mem_req,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [3:0]            instr_opcode,
    output logic [DATA_WIDTH-5:0] instr_operand,
    output logic [ADDR_WIDTH-1:0] instr_address
);
    typedef enum logic [2:0] {IDLE, REQ, CAPTURE, RELEASE, PRESENT} state_t;
    localparam logic [3:0] OP_JMP = 4'hC;
    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  mem_req_q, mem_req_d;
    logic                  valid_q, valid_d;
    logic [3:0]            opcode_q, opcode_d;
    logic [DATA_WIDTH-5:0] operand_q, operand_d;
    logic [ADDR_WIDTH-1:0] address_q, address_d;
    logic                  ack_s;
`ifdef FETCH_ACK_SYNC_EN
    logic [1:0] ack_sync_q;
    always_ff @(posedge clk) begin
        ack_sync_q <= reset ? 2'b00 : {ack_sync_q[0], mem_ack};
    end
    assign ack_s = ack_sync_q[1];
`else
    assign ack_s = mem_ack;
`endif
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        mem_req_d = mem_req_q;
        valid_d   = valid_q;
        opcode_d  = opcode_q;
        operand_d = operand_q;
        address_d = address_q;
        case (state_q)
            IDLE: if (!ack_s) begin
                state_d   = REQ;
                mem_req_d = 1'b1;
            end
            REQ: if (ack_s) state_d = CAPTURE;
            CAPTURE: begin
                opcode_d  = mem_data[DATA_WIDTH-1 -: 4];
                operand_d = mem_data[DATA_WIDTH-5:0];
                address_d = pc_q;
                mem_req_d = 1'b0;
                state_d   = RELEASE;
            end
            RELEASE: if (!ack_s) begin
                state_d = PRESENT;
                valid_d = 1'b1;
            end
            PRESENT: if (instr_ready) begin
                valid_d   = 1'b0;
                mem_req_d = 1'b1;
                state_d   = REQ;
                // JMP target is the operand cast to PC width (zero-extend or truncate)
                pc_d      = (opcode_q == OP_JMP) ? ADDR_WIDTH'(operand_q) : pc_q + ADDR_WIDTH'(1);
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
                valid_d   = 1'b0;
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            mem_req_q <= 1'b0;
            valid_q   <= 1'b0;
            opcode_q  <= '0;
            operand_q <= '0;
            address_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            mem_req_q <= mem_req_d;
            valid_q   <= valid_d;
            opcode_q  <= opcode_d;
            operand_q <= operand_d;
            address_q <= address_d;
        end
    end
    assign read_address  = pc_q;
    assign mem_req       = mem_req_q;
    assign instr_valid   = valid_q;
    assign instr_opcode  = opcode_q;
    assign instr_operand = operand_q;
    assign instr_address = address_q;
endmodule

// File: tb/tb_mc14500_fetch.sv
// tb_mc14500_fetch: scoreboard bench for mc14500_fetch with a 16-word RAM and combinational ack.
module tb_mc14500_fetch;
    localparam int DW = 8;
    localparam int AW = 4;
    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] read_address;
    logic          mem_req, mem_ack, instr_valid, instr_ready = 1'b0;
    logic [DW-1:0] mem_data;
    logic [3:0]    instr_opcode;
    logic [DW-5:0] instr_operand;
    logic [AW-1:0] instr_address;
    logic          ack_override = 1'b1, ack_val = 1'b0;
    logic [DW-1:0] ram [16];
    logic [11:0]   sb [$];
    int            vectors = 0, errors = 0;

    mc14500_fetch #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESET_PC(4'd0)) dut (
        .clk(clk), .reset(reset), .read_address(read_address), .mem_req(mem_req),
        .mem_ack(mem_ack), .mem_data(mem_data), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .instr_opcode(instr_opcode),
        .instr_operand(instr_operand), .instr_address(instr_address));

    always #5 clk = ~clk;
    assign mem_ack  = ack_override ? ack_val : mem_req;
    assign mem_data = ram[read_address];

    task automatic fetch_one(output bit to, output logic [11:0] got);
        to = 1'b1;
        got = '0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (instr_valid === 1'b1) begin
                to = 1'b0;
                break;
            end
        end
        got = {instr_opcode, instr_operand, instr_address};
        @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        ack_override = 1'b1;
        ack_val = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({mem_req, instr_valid, read_address, instr_opcode, instr_operand, instr_address} !== '0) begin
            errors++;
            $display("FAIL reset_state got req=%b valid=%b addr=%h op=%h opr=%h ia=%h required all 0",
                     mem_req, instr_valid, read_address, instr_opcode, instr_operand, instr_address);
        end
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if (mem_req !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_req got %b required 1", mem_req);
        end
        ack_override = 1'b0;
    endtask

    task automatic test_linear;
        bit to;
        logic [11:0] got, e;
        instr_ready = 1'b1;
        sb.push_back({4'h1, 4'h2, 4'h0});
        sb.push_back({4'h3, 4'hA, 4'h1});
        sb.push_back({4'h4, 4'h7, 4'h2});
        for (int i = 0; i < 3; i++) begin
            fetch_one(to, got);
            e = sb.pop_front();
            vectors++;
            if (to || got !== e) begin
                errors++;
                $display("FAIL linear_%0d got %h (timeout=%b) required %h", i, got, to, e);
            end
            vectors++;
            if (instr_valid !== 1'b0) begin
                errors++;
                $display("FAIL linear_pulse_%0d valid got %b required 0", i, instr_valid);
            end
        end
    endtask

    task automatic test_jump;
        bit to;
        logic [11:0] got, e;
        sb.push_back({4'hC, 4'h5, 4'h3});
        sb.push_back({4'hC, 4'h9, 4'h5});
        sb.push_back({4'hC, 4'hF, 4'h9});
        for (int i = 0; i < 3; i++) begin
            fetch_one(to, got);
            e = sb.pop_front();
            vectors++;
            if (to || got !== e) begin
                errors++;
                $display("FAIL jump_%0d got %h (timeout=%b) required %h", i, got, to, e);
            end
            if (i == 1) begin
                vectors++;
                if (read_address !== 4'd9) begin
                    errors++;
                    $display("FAIL jump_target read_address got %h required 9", read_address);
                end
            end
        end
    endtask

    task automatic test_wrap;
        bit to;
        logic [11:0] got, e;
        sb.push_back({4'h6, 4'hE, 4'hF});
        fetch_one(to, got);
        e = sb.pop_front();
        vectors++;
        if (to || got !== e) begin
            errors++;
            $display("FAIL wrap_instr got %h (timeout=%b) required %h", got, to, e);
        end
        vectors++;
        if (read_address !== 4'd0) begin
            errors++;
            $display("FAIL wrap_pc read_address got %h required 0", read_address);
        end
    endtask

    task automatic test_backpressure;
        bit to;
        logic [11:0] got, e;
        instr_ready = 1'b0;
        sb.push_back({4'h1, 4'h2, 4'h0});
        fetch_one(to, got);
        e = sb.pop_front();
        vectors++;
        if (to || got !== e) begin
            errors++;
            $display("FAIL bp_instr got %h (timeout=%b) required %h", got, to, e);
        end
        for (int i = 0; i < 10; i++) begin
            vectors++;
            if (instr_valid !== 1'b1 || {instr_opcode, instr_operand, instr_address} !== e ||
                mem_req !== 1'b0 || read_address !== 4'd0) begin
                errors++;
                $display("FAIL bp_hold_%0d got valid=%b word=%h req=%b pc=%h required 1 %h 0 0",
                         i, instr_valid, {instr_opcode, instr_operand, instr_address}, mem_req, read_address, e);
            end
            @(negedge clk);
        end
        instr_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if (instr_valid !== 1'b0 || read_address !== 4'd1) begin
            errors++;
            $display("FAIL bp_release got valid=%b pc=%h required 0 1", instr_valid, read_address);
        end
    endtask

    task automatic test_stale_ack;
        int n;
        ack_override = 1'b1;
        ack_val = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        vectors++;
        if (mem_req !== 1'b0) begin
            errors++;
            $display("FAIL stale_reset_drop req got %b required 0", mem_req);
        end
`ifndef FETCH_ACK_SYNC_EN
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (mem_req !== 1'b0) begin
                errors++;
                $display("FAIL stale_hold_%0d req got %b required 0", i, mem_req);
            end
        end
        ack_val = 1'b0;
        n = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (mem_req === 1'b1) begin
                n = i;
                break;
            end
        end
        vectors++;
        if (n != 1) begin
            errors++;
            $display("FAIL stale_release cycles to req got %0d required 1", n);
        end
`else
        repeat (3) @(negedge clk);
        ack_val = 1'b0;
        repeat (4) @(negedge clk);
`endif
        ack_override = 1'b0;
    endtask

    task automatic test_back_to_back;
        bit to;
        logic [11:0] got, e;
        instr_ready = 1'b1;
        sb.push_back({4'h1, 4'h2, 4'h0});
        sb.push_back({4'h3, 4'hA, 4'h1});
        for (int i = 0; i < 2; i++) begin
            fetch_one(to, got);
            e = sb.pop_front();
            vectors++;
            if (to || got !== e) begin
                errors++;
                $display("FAIL b2b_%0d got %h (timeout=%b) required %h", i, got, to, e);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) ram[i] = 8'h00;
        ram[0] = 8'h12; ram[1] = 8'h3A; ram[2] = 8'h47; ram[3] = 8'hC5;
        ram[5] = 8'hC9; ram[9] = 8'hCF; ram[15] = 8'h6E;
        test_reset();
        test_linear();
        test_jump();
        test_wrap();
        test_backpressure();
        test_stale_ack();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
